// File: rtl/edge_frame_sender.sv
// edge_frame_sender
//   Packs a raster stream of binary edge pixels into WORD_BITS-wide words
//   and hands each finished word downstream with a one-cycle strobe. After
//   WORDS_PER_FRAME words the block parks until the downstream Hough engine
//   reports a fresh completion edge, then returns to idle for the next frame.
//
// Ports
//   clock        rising-edge system clock
//   reset        asynchronous, active-low reset
//   pix_valid    upstream pixel present
//   pix_data     binary edge pixel, raster order
//   pix_sof      marks the first pixel of a frame
//   pix_ready    block accepts a pixel this cycle
//   hough_ready  level: downstream Hough pass finished
//   data         packed word, bit k = k-th pixel of the word
//   valid        one-cycle word strobe
//   word_count   words sent in the current frame
//   frame_busy   frame in progress (first pixel through handoff)
//   frame_done   one-cycle pulse on downstream completion
//   sof_error    one-cycle pulse when a frame restarts mid-frame
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a start-of-frame pixel, non-sof pixels dropped
// PACK      | filling the current word one pixel per transfer
// SEND      | one-cycle word strobe, no pixels accepted
// WAIT_DONE | frame fully sent, waiting for a hough_ready rising edge

module edge_frame_sender #(
  parameter int WORD_BITS       = 240,
  parameter int WORDS_PER_FRAME = 1280,
  parameter int CNT_W           = 11
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic                 pix_data,
  input  logic                 pix_sof,
  output logic                 pix_ready,
  input  logic                 hough_ready,
  output logic [WORD_BITS-1:0] data,
  output logic                 valid,
  output logic [CNT_W-1:0]     word_count,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 sof_error
);

  localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_WORDS = CNT_W'(WORDS_PER_FRAME);

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    PACK      = 4'b0010,
    SEND      = 4'b0100,
    WAIT_DONE = 4'b1000
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_nxt;
  logic [WORD_BITS-1:0] data_nxt;
  logic [CNT_W-1:0]     word_count_nxt;
  logic [CNT_W-1:0]     word_inc;
  logic                 frame_busy_nxt;
  logic                 frame_done_nxt;
  logic                 sof_error_nxt;
  logic                 hough_q;
  logic                 hough_rise;
  logic                 mid_frame;

  // hough_q samples every cycle, so a level already high when WAIT_DONE is
  // entered shows no rise; only a genuine 0->1 transition completes the frame.
  assign hough_rise = hough_ready & ~hough_q;

  // A sof at the very first bit slot of word 0 is an ordinary first pixel.
  assign mid_frame = (bit_cnt != '0) || (word_count != '0);

  // Saturating increment keeps word_count from ever passing the frame size.
  assign word_inc = (word_count >= FRAME_WORDS) ? word_count : word_count + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pix_ready      = 1'b0;
    valid          = 1'b0;
    data_nxt       = data;
    bit_cnt_nxt    = bit_cnt;
    word_count_nxt = word_count;
    frame_busy_nxt = frame_busy;
    frame_done_nxt = 1'b0;
    sof_error_nxt  = 1'b0;

    case (state)
      IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid && pix_sof) begin
          data_nxt[0]    = pix_data;
          bit_cnt_nxt    = BIT_W'(1);
          word_count_nxt = '0;
          frame_busy_nxt = 1'b1;
          state_nxt      = PACK;
        end
      end

      PACK: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          if (pix_sof && mid_frame) begin
            // Restart: the partial frame is abandoned, the sof pixel becomes
            // bit 0 of word 0. Stale upper bits are overwritten before the
            // next strobe, so they are not cleared here.
            sof_error_nxt  = 1'b1;
            data_nxt[0]    = pix_data;
            bit_cnt_nxt    = BIT_W'(1);
            word_count_nxt = '0;
          end else begin
            data_nxt[bit_cnt] = pix_data;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_nxt = '0;
              state_nxt   = SEND;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end
      end

      SEND: begin
        valid          = 1'b1;
        word_count_nxt = word_inc;
        state_nxt      = (word_inc == FRAME_WORDS) ? WAIT_DONE : PACK;
      end

      WAIT_DONE: begin
        if (hough_rise) begin
          frame_done_nxt = 1'b1;
          frame_busy_nxt = 1'b0;
          word_count_nxt = '0;
          state_nxt      = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data       <= '0;
      bit_cnt    <= '0;
      word_count <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      sof_error  <= 1'b0;
      hough_q    <= 1'b0;
    end else begin
      data       <= data_nxt;
      bit_cnt    <= bit_cnt_nxt;
      word_count <= word_count_nxt;
      frame_busy <= frame_busy_nxt;
      frame_done <= frame_done_nxt;
      sof_error  <= sof_error_nxt;
      hough_q    <= hough_ready;
    end
  end

endmodule

// File: doc/edge_frame_sender.md
EDGE_FRAME_SENDER -- requirements
Module: edge_frame_sender

Interface
REQ-001 Parameter WORD_BITS, default 240: pixels packed per output word.
REQ-002 Parameter WORDS_PER_FRAME, default 1280: words per 640x480 binary frame (307200 pixels).
REQ-003 Parameter CNT_W, default 11: width of word counter.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 pix_valid  input  1  upstream pixel present on pix_data.
REQ-007 pix_data  input  1  binary edge pixel, raster order (x fastest, y slowest).
REQ-008 pix_sof  input  1  qualifies first pixel of a frame (x=0,y=0).
REQ-009 pix_ready  output  1  block accepts pixel this cycle; transfer = pix_valid & pix_ready.
REQ-010 hough_ready  input  1  level "Hough pass finished" from the downstream Hough engine.
REQ-011 data  output  WORD_BITS  packed word; bit k = k-th pixel of the word.
REQ-012 valid  output  1  one-cycle word strobe; data stable whenever valid=1.
REQ-013 word_count  output  CNT_W  words sent in current frame.
REQ-014 frame_busy  output  1  high from first accepted pixel until frame handoff completes.
REQ-015 frame_done  output  1  one-cycle pulse when downstream signals completion of the sent frame.
REQ-016 sof_error  output  1  one-cycle pulse on pix_sof arriving mid-frame.

Function
REQ-017 States: IDLE, PACK, SEND, WAIT_DONE; one-hot encoding, illegal state -> IDLE next cycle.
REQ-018 IDLE: pix_ready=1; transfers with pix_sof=0 dropped; transfer with pix_sof=1 stores pix_data at bit 0, bit_cnt=1, word_count=0, frame_busy=1, -> PACK.
REQ-019 PACK: pix_ready=1; each transfer writes pix_data to data[bit_cnt], bit_cnt+1; pix_valid=0 holds all state.
REQ-020 PACK: transfer with bit_cnt=WORD_BITS-1 -> SEND next cycle, bit_cnt=0.
REQ-021 SEND: lasts exactly one cycle; valid=1, pix_ready=0; word_count increments at end of cycle.
REQ-022 SEND exit: if incremented word_count = WORDS_PER_FRAME -> WAIT_DONE, else -> PACK.
REQ-023 valid is 0 in every state except SEND; consecutive valid pulses separated by >=WORD_BITS cycles (downstream counts valid edges).
REQ-024 data bits not yet written in current word retain prior values; only valid-qualified content is defined.
REQ-025 WAIT_DONE: pix_ready=0; hough_ready sampled by register; rising edge (0->1) -> frame_done=1 one cycle, frame_busy=0, word_count=0, -> IDLE.
REQ-026 hough_ready already high on WAIT_DONE entry does not complete the frame; a fresh 0->1 edge is required.
REQ-027 PACK with transfer carrying pix_sof=1 and (bit_cnt!=0 or word_count!=0): sof_error=1 one cycle, partial frame discarded, pixel stored as bit 0 of word 0, word_count=0, bit_cnt=1, stay PACK.
REQ-028 pix_sof=1 exactly at bit_cnt=0, word_count=0 in PACK: not an error (cannot occur after REQ-018; treated as normal first pixel).
REQ-029 word_count saturates: never exceeds WORDS_PER_FRAME; wraps to 0 only per REQ-025/REQ-027.
REQ-030 pix_sof ignored in SEND and WAIT_DONE (pix_ready=0, no transfer).

Reset
REQ-031 reset=0 asynchronously forces: state IDLE, data=0, bit_cnt=0, word_count=0, valid=0, frame_busy=0, frame_done=0, sof_error=0, hough_ready sample register=0.
REQ-032 Reset mid-frame discards all partial data; no valid pulse issued for partial word after release.
REQ-033 First transfer honoured on first rising clock edge after reset deasserts.

Verification
REQ-034 Reset then 240 back-to-back pixels, sof on first, pattern alternating 1/0 -> one valid pulse cycle 241 after first transfer, data = 240'h5...5 pattern (bit0=1), word_count=1.
REQ-035 Full frame 307200 pixels with random pix_valid gaps -> exactly 1280 valid pulses, each one cycle, pix_ready=0 during SEND, state WAIT_DONE with word_count=1280.
REQ-036 In WAIT_DONE hold hough_ready=1 from entry, then 0, then 1 -> frame_done only after the 0->1 edge; pixels offered during wait not accepted.
REQ-037 pix_sof at pixel 100 of word 3 -> sof_error one cycle, word_count=0, next valid 239 transfers later contains new frame pixel at bit 0.
REQ-038 In IDLE offer 50 pixels without sof then sof pixel -> first 50 dropped, frame_busy rises on sof transfer.
REQ-039 Assert reset during pixel 120 of word 5 -> all outputs to reset values immediately; after release, no valid until a new sof plus 240 transfers.
